// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage after the addressing-mode sequencer.
// Executes 6502 group-01 ALU ops (ORA/AND/EOR/ADC/STA/LDA/CMP/SBC) and
// CLC/SEC/CLD/SED. Owns the accumulator and status register. Stores go out
// as a held write request that completes on an ack.
//
// Optional feature macro: DECIMAL_MODE_EN. When defined, ADC/SBC do BCD
// arithmetic while D = 1. When undefined, D is stored but ignored.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_op_valid  upstream presents an op
//   o_op_ready  stage can accept (IDLE only)
//   i_opcode    opcode byte: [7:5] op, [4:2] amode, [1:0] group
//   i_operand   fetched operand byte
//   i_eff_addr  effective address (STA only)
//   o_reg_a     accumulator
//   o_p_flags   status {N,V,1,B,D,I,Z,C}
//   o_wr_req    memory write request, held until i_wr_ack
//   o_wr_addr   write address
//   o_wr_data   write data
//   i_wr_ack    memory accepted the write
//   o_done      one-cycle pulse when an op retires
module exec_unit #(
    parameter logic [7:0] P_RESET = 8'h24,
    parameter logic [7:0] A_RESET = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [7:0]  i_opcode,
    input  logic [7:0]  i_operand,
    input  logic [15:0] i_eff_addr,
    output logic [7:0]  o_reg_a,
    output logic [7:0]  o_p_flags,
    output logic        o_wr_req,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    input  logic        i_wr_ack,
    output logic        o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_opcode;
    logic [7:0]  r_operand;
    logic [15:0] r_addr;
    logic [7:0]  r_a;
    logic [7:0]  r_p;
    logic        r_done;

    logic [7:0]  w_m_inv;
    logic [8:0]  w_adc_sum;
    logic [8:0]  w_sbc_sum;
    logic [8:0]  w_cmp_sum;
    logic [7:0]  w_a_next;
    logic [7:0]  w_p_next;
    logic        w_is_store;
    logic        w_upd_nz;

`ifdef DECIMAL_MODE_EN
    logic [4:0]  w_dal;
    logic [4:0]  w_dah;
    logic [4:0]  w_dsl;
    logic [4:0]  w_dsh;
    logic        w_dal_c;
    logic        w_dah_c;
    logic        w_dsl_b;
    logic        w_dsh_b;
    logic [3:0]  w_dal_adj;
    logic [3:0]  w_dah_adj;
    logic [3:0]  w_dsl_adj;
    logic [3:0]  w_dsh_adj;

    // Nibble-serial BCD: add adjusts by +6 past 9, subtract by -6 on borrow.
    // Subtraction nibbles are 5-bit so bit 4 is the borrow/sign.
    always_comb begin
        w_dal     = {1'b0, r_a[3:0]} + {1'b0, r_operand[3:0]} + {4'd0, r_p[0]};
        w_dal_c   = (w_dal > 5'd9);
        w_dal_adj = w_dal_c ? (w_dal[3:0] + 4'd6) : w_dal[3:0];
        w_dah     = {1'b0, r_a[7:4]} + {1'b0, r_operand[7:4]} + {4'd0, w_dal_c};
        w_dah_c   = (w_dah > 5'd9);
        w_dah_adj = w_dah_c ? (w_dah[3:0] + 4'd6) : w_dah[3:0];
        w_dsl     = {1'b0, r_a[3:0]} - {1'b0, r_operand[3:0]} - {4'd0, ~r_p[0]};
        w_dsl_b   = w_dsl[4];
        w_dsl_adj = w_dsl_b ? (w_dsl[3:0] - 4'd6) : w_dsl[3:0];
        w_dsh     = {1'b0, r_a[7:4]} - {1'b0, r_operand[7:4]} - {4'd0, w_dsl_b};
        w_dsh_b   = w_dsh[4];
        w_dsh_adj = w_dsh_b ? (w_dsh[3:0] - 4'd6) : w_dsh[3:0];
    end
`endif

    // Result of the captured op; only committed in EXEC.
    always_comb begin
        w_m_inv    = ~r_operand;
        w_adc_sum  = {1'b0, r_a} + {1'b0, r_operand} + {8'd0, r_p[0]};
        w_sbc_sum  = {1'b0, r_a} + {1'b0, w_m_inv} + {8'd0, r_p[0]};
        w_cmp_sum  = {1'b0, r_a} + {1'b0, w_m_inv} + 9'd1;
        w_a_next   = r_a;
        w_p_next   = r_p;
        w_is_store = 1'b0;
        w_upd_nz   = 1'b0;
        if (r_opcode[1:0] == 2'b01) begin
            unique case (r_opcode[7:5])
                3'b000: begin
                    w_a_next = r_a | r_operand;
                    w_upd_nz = 1'b1;
                end
                3'b001: begin
                    w_a_next = r_a & r_operand;
                    w_upd_nz = 1'b1;
                end
                3'b010: begin
                    w_a_next = r_a ^ r_operand;
                    w_upd_nz = 1'b1;
                end
                3'b011: begin
                    w_a_next    = w_adc_sum[7:0];
                    w_p_next[0] = w_adc_sum[8];
                    w_p_next[6] = (r_a[7] ^ w_adc_sum[7]) & (r_operand[7] ^ w_adc_sum[7]);
`ifdef DECIMAL_MODE_EN
                    if (r_p[3]) begin
                        w_a_next    = {w_dah_adj, w_dal_adj};
                        w_p_next[0] = w_dah_c;
                    end
`endif
                    w_upd_nz = 1'b1;
                end
                // 0x89 (STA immediate) has nowhere to store, so it retires as a NOP.
                3'b100: w_is_store = (r_opcode != 8'h89);
                3'b101: begin
                    w_a_next = r_operand;
                    w_upd_nz = 1'b1;
                end
                3'b110: begin
                    w_p_next[0] = w_cmp_sum[8];
                    w_p_next[7] = w_cmp_sum[7];
                    w_p_next[1] = (w_cmp_sum[7:0] == 8'd0);
                end
                3'b111: begin
                    w_a_next    = w_sbc_sum[7:0];
                    w_p_next[0] = w_sbc_sum[8];
                    w_p_next[6] = (r_a[7] ^ w_sbc_sum[7]) & (w_m_inv[7] ^ w_sbc_sum[7]);
`ifdef DECIMAL_MODE_EN
                    if (r_p[3]) begin
                        w_a_next    = {w_dsh_adj, w_dsl_adj};
                        w_p_next[0] = ~w_dsh_b;
                    end
`endif
                    w_upd_nz = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (r_opcode)
                8'h18:   w_p_next[0] = 1'b0;
                8'h38:   w_p_next[0] = 1'b1;
                8'hD8:   w_p_next[3] = 1'b0;
                8'hF8:   w_p_next[3] = 1'b1;
                default: ;
            endcase
        end
        if (w_upd_nz) begin
            w_p_next[7] = w_a_next[7];
            w_p_next[1] = (w_a_next == 8'd0);
        end
        w_p_next[5] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= A_RESET;
            r_p     <= P_RESET | 8'h20;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_op_valid) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_a <= w_a_next;
                    r_p <= w_p_next;
                    if (w_is_store) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (i_wr_ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand capture needs no reset: only read after a handshake.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_op_valid) begin
            r_opcode  <= i_opcode;
            r_operand <= i_operand;
            r_addr    <= i_eff_addr;
        end
    end

    assign o_op_ready = (r_state == S_IDLE);
    assign o_wr_req   = (r_state == S_WRITE);
    assign o_wr_addr  = r_addr;
    assign o_wr_data  = r_a;
    assign o_reg_a    = r_a;
    assign o_p_flags  = r_p;
    assign o_done     = r_done;

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed test-plan cases plus randomized ops,
// checked by a scoreboard fed from a behavioural 6502 ALU model.
`timescale 1ns/1ps
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_op_valid;
    logic        o_op_ready;
    logic [7:0]  i_opcode;
    logic [7:0]  i_operand;
    logic [15:0] i_eff_addr;
    logic [7:0]  o_reg_a;
    logic [7:0]  o_p_flags;
    logic        o_wr_req;
    logic [15:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        i_wr_ack = 1'b0;
    logic        o_done;

    always #5 clk = ~clk;

    exec_unit #(
        .P_RESET(8'h24),
        .A_RESET(8'h00)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_op_valid (i_op_valid),
        .o_op_ready (o_op_ready),
        .i_opcode   (i_opcode),
        .i_operand  (i_operand),
        .i_eff_addr (i_eff_addr),
        .o_reg_a    (o_reg_a),
        .o_p_flags  (o_p_flags),
        .o_wr_req   (o_wr_req),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_wr_ack   (i_wr_ack),
        .o_done     (o_done)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] p;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb_q[$];
    logic [23:0] st_q[$];
    logic [7:0]  m_a;
    logic [7:0]  m_p;
    int          g_ack_delay = 1;
    int          wr_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one op applied to m_a/m_p.
    task automatic model_exec(input logic [7:0] op, input logic [7:0] m);
        int a, mm, mi, c, r, lo, hi, res;
        bit upd, lo_b, hi_b, cf;
        a = m_a; mm = m; mi = (~mm) & 255; c = m_p[0]; res = a; upd = 0;
        if (op[1:0] == 2'b01) begin
            case (op[7:5])
                3'd0: begin res = a | mm; upd = 1; end
                3'd1: begin res = a & mm; upd = 1; end
                3'd2: begin res = a ^ mm; upd = 1; end
                3'd3: begin
                    r = a + mm + c;
                    m_p[6] = (((a ^ r) & (mm ^ r) & 128) != 0);
                    res = r & 255; cf = (r > 255);
`ifdef DECIMAL_MODE_EN
                    if (m_p[3]) begin
                        lo = (a & 15) + (mm & 15) + c;
                        if (lo > 9) lo = lo + 6;
                        hi = (a >> 4) + (mm >> 4) + ((lo > 15) ? 1 : 0);
                        if (hi > 9) hi = hi + 6;
                        res = ((hi & 15) << 4) | (lo & 15);
                        cf = (hi > 15);
                    end
`endif
                    m_p[0] = cf; upd = 1;
                end
                3'd4: ;
                3'd5: begin res = mm; upd = 1; end
                3'd6: begin
                    r = a + mi + 1;
                    m_p[0] = (r > 255);
                    m_p[7] = ((r & 128) != 0);
                    m_p[1] = ((r & 255) == 0);
                end
                default: begin
                    r = a + mi + c;
                    m_p[6] = (((a ^ r) & (mi ^ r) & 128) != 0);
                    res = r & 255; cf = (r > 255);
`ifdef DECIMAL_MODE_EN
                    if (m_p[3]) begin
                        lo = (a & 15) - (mm & 15) - (1 - c);
                        lo_b = (lo < 0);
                        if (lo_b) lo = lo - 6;
                        hi = (a >> 4) - (mm >> 4) - (lo_b ? 1 : 0);
                        hi_b = (hi < 0);
                        if (hi_b) hi = hi - 6;
                        res = ((hi & 15) << 4) | (lo & 15);
                        cf = !hi_b;
                    end
`endif
                    m_p[0] = cf; upd = 1;
                end
            endcase
        end else begin
            case (op)
                8'h18: m_p[0] = 1'b0;
                8'h38: m_p[0] = 1'b1;
                8'hD8: m_p[3] = 1'b0;
                8'hF8: m_p[3] = 1'b1;
                default: ;
            endcase
        end
        if (upd) begin
            m_a = res[7:0];
            m_p[7] = m_a[7];
            m_p[1] = (m_a == 8'd0);
        end
    endtask

    // Entered and left on a negedge; returns in the EXEC cycle.
    task automatic issue(input logic [7:0] op, input logic [7:0] m, input logic [15:0] addr,
                         input int dly);
        int t = 0;
        i_op_valid = 1'b1; i_opcode = op; i_operand = m; i_eff_addr = addr;
        while (o_op_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL ready_timeout: got %0b expected 1", o_op_ready);
                i_op_valid = 1'b0;
                return;
            end
        end
        g_ack_delay = dly;
        @(posedge clk);
        if (op[1:0] == 2'b01 && op[7:5] == 3'd4 && op != 8'h89) st_q.push_back({addr, m_a});
        model_exec(op, m);
        sb_q.push_back('{a: m_a, p: m_p});
        @(negedge clk);
        i_op_valid = 1'b0;
        i_opcode = 8'($urandom); i_operand = 8'($urandom); i_eff_addr = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: every DONE retires the oldest expected result.
    always @(negedge clk) begin
        if (mon_en && o_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("reg_a", o_reg_a, e.a);
                chk("p_flags", o_p_flags, e.p);
                chk("ready_at_done", o_op_ready, 1);
            end
        end
    end

    // Memory responder: acks after g_ack_delay request cycles, random ack noise otherwise.
    always @(negedge clk) begin
        if (o_wr_req === 1'b1) begin
            wr_cnt++;
            if (st_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_wr_req: got 1 expected 0 at %0t", $time);
            end else begin
                chk("wr_addr", o_wr_addr, st_q[0][23:8]);
                chk("wr_data", o_wr_data, st_q[0][7:0]);
            end
            if (wr_cnt >= g_ack_delay) begin
                i_wr_ack = 1'b1;
                if (st_q.size() != 0) void'(st_q.pop_front());
            end else begin
                i_wr_ack = 1'b0;
            end
        end else begin
            wr_cnt = 0;
            i_wr_ack = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int cnt;
        logic [7:0] op;
        logic [2:0] f;
        logic [2:0] am;
        i_rst = 1'b1; i_op_valid = 1'b0; i_opcode = 8'h00; i_operand = 8'h00; i_eff_addr = 16'h0;
        @(negedge clk);
        i_rst = 1'b0;
        m_a = 8'h00; m_p = 8'h24;
        chk("rst_reg_a", o_reg_a, 8'h00);
        chk("rst_p", o_p_flags, 8'h24);
        chk("rst_ready", o_op_ready, 1);
        chk("rst_wr_req", o_wr_req, 0);
        chk("rst_done", o_done, 0);
        mon_en = 1'b1;

        // LDA #80 timing
        issue(8'hA9, 8'h80, 16'h0, 1);
        chk("lda_ready_busy", o_op_ready, 0);
        chk("lda_done_early", o_done, 0);
        @(negedge clk);
        chk("lda_done", o_done, 1);
        chk("lda_a", o_reg_a, 8'h80);
        chk("lda_n", o_p_flags[7], 1);
        chk("lda_z", o_p_flags[1], 0);
        @(negedge clk);
        chk("lda_done_pulse", o_done, 0);

        // CLD; CLC; LDA #50; ADC #50
        issue(8'hD8, 8'h00, 16'h0, 1);
        issue(8'h18, 8'h00, 16'h0, 1);
        issue(8'hA9, 8'h50, 16'h0, 1);
        issue(8'h69, 8'h50, 16'h0, 1);
        drain();
        chk("adc_a", o_reg_a, 8'hA0);
        chk("adc_n", o_p_flags[7], 1);
        chk("adc_v", o_p_flags[6], 1);
        chk("adc_c", o_p_flags[0], 0);
        chk("adc_z", o_p_flags[1], 0);

        // CMP
        issue(8'hA9, 8'h40, 16'h0, 1);
        issue(8'hC9, 8'h41, 16'h0, 1);
        drain();
        chk("cmp_lt_c", o_p_flags[0], 0);
        chk("cmp_lt_n", o_p_flags[7], 1);
        chk("cmp_lt_z", o_p_flags[1], 0);
        chk("cmp_a", o_reg_a, 8'h40);
        issue(8'hC9, 8'h40, 16'h0, 1);
        drain();
        chk("cmp_eq_z", o_p_flags[1], 1);
        chk("cmp_eq_c", o_p_flags[0], 1);

        // STA abs with ack after 3 request cycles
        issue(8'hA9, 8'h5A, 16'h0, 1);
        drain();
        issue(8'h8D, 8'h00, 16'h1234, 3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) break;
            chk("sta_ready_low", o_op_ready, 0);
            if (o_wr_req === 1'b1) begin
                cnt++;
                chk("sta_addr", o_wr_addr, 16'h1234);
                chk("sta_data", o_wr_data, 8'h5A);
            end
        end
        chk("sta_done", o_done, 1);
        chk("sta_req_cycles", cnt, 3);
        chk("sta_req_dropped", o_wr_req, 0);
        @(negedge clk);

        // STA aborted by reset mid-write
        issue(8'h8D, 8'h00, 16'h1234, 100);
        @(negedge clk);
        @(negedge clk);
        chk("abort_req_high", o_wr_req, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        sb_q.delete(); st_q.delete();
        m_a = 8'h00; m_p = 8'h24;
        chk("abort_req_low", o_wr_req, 0);
        chk("abort_no_done", o_done, 0);
        chk("abort_ready", o_op_ready, 1);
        chk("abort_a", o_reg_a, 8'h00);
        @(negedge clk);
        chk("abort_no_done2", o_done, 0);

        // SED; CLC; LDA #19; ADC #28
        issue(8'hF8, 8'h00, 16'h0, 1);
        issue(8'h18, 8'h00, 16'h0, 1);
        issue(8'hA9, 8'h19, 16'h0, 1);
        issue(8'h69, 8'h28, 16'h0, 1);
        drain();
`ifdef DECIMAL_MODE_EN
        chk("bcd_adc_a", o_reg_a, 8'h47);
`else
        chk("bcd_adc_a", o_reg_a, 8'h41);
`endif
        chk("sed_d", o_p_flags[3], 1);

        // Randomized ops
        for (int i = 0; i < 300; i++) begin
            cnt = $urandom_range(0, 9);
            if (cnt < 6) begin
                f = 3'($urandom_range(0, 7));
                am = 3'($urandom_range(0, 7));
                op = {f, am, 2'b01};
            end else if (cnt < 8) begin
                case ($urandom_range(0, 3))
                    0: op = 8'h18;
                    1: op = 8'h38;
                    2: op = 8'hD8;
                    default: op = 8'hF8;
                endcase
            end else begin
                op = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            issue(op, 8'($urandom), 16'($urandom), $urandom_range(1, 4));
        end
        drain();
        if (st_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL store_pending: got %0d expected 0", st_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute/writeback stage directly downstream of the addressing-mode sequencer.
- Accepts a decoded opcode plus its fetched operand byte (or its effective address, for stores).
- Executes 6502 group-01 ALU ops plus CLC/SEC/CLD/SED.
- Owns the architectural accumulator and processor status register, and issues store write requests to memory with an ack handshake.

Parameters:
- P_RESET, 8'h24, reset value of status register (bit5 = 1, I = 1).
- A_RESET, 8'h00, reset value of accumulator.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- R  in  1  reset, synchronous, active-high.
- OP_VALID  in  1  upstream presents an op.
- OP_READY  out  1  stage can accept; high only in IDLE.
- OPCODE  in  8  full opcode byte; bits 7:5 = opcode, 4:2 = amode, 1:0 = group.
- OPERAND  in  8  fetched data byte; ignored for STA and flag ops.
- EFF_ADDR  in  16  effective address; used by STA only.
- REG_A  out  8  accumulator.
- P_FLAGS  out  8  status register {N,V,1,B,D,I,Z,C}.
- WR_REQ  out  1  memory write request.
- WR_ADDR  out  16  write address; stable while WR_REQ is high.
- WR_DATA  out  8  write data; stable while WR_REQ is high.
- WR_ACK  in  1  memory accepted the write.
- DONE  out  1  one-cycle pulse when an op retires.

Behaviour:
- Reset (R sampled high at an edge):
  - state = IDLE; REG_A = A_RESET; P_FLAGS = P_RESET.
  - WR_REQ = 0; DONE = 0; OP_READY = 1 in the following cycle.
  - Applies from any state. An op in flight is discarded: no DONE, WR_REQ drops.
- States:
  - IDLE: OP_READY = 1. On OP_VALID = 1, capture OPCODE, OPERAND and EFF_ADDR, then go to EXEC. Otherwise stay.
  - EXEC: one cycle. Compute the result; commit REG_A/P at the closing edge.
    - STA: go to WRITE.
    - All other ops: go to IDLE; DONE = 1 in the next cycle.
  - WRITE: WR_REQ = 1, WR_ADDR = captured address, WR_DATA = REG_A. Hold until WR_ACK is sampled high. Then go to IDLE; WR_REQ = 0 and DONE = 1 in the next cycle.
- Timing:
  - Handshake edge T0, non-store op: REG_A/P valid and DONE high in cycle T0+2.
  - Throughput is one op per 2 cycles minimum.
  - OP_READY is low in EXEC and WRITE.
  - WR_ACK is ignored outside WRITE.
- Group 01 (OPCODE[1:0] = 01), by OPCODE[7:5]:
  - 000 ORA, 001 AND, 010 EOR: A = A op M; set N, Z.
  - 011 ADC: {C,A} = A + M + C; V = (A^r)&(M^r)&8'h80; set N, Z.
  - 100 STA: write A; no flag change. Opcode 0x89 is treated as NOP.
  - 101 LDA: A = M; set N, Z.
  - 110 CMP: r = A + ~M + 1; C = carry out, N = r[7], Z = (r == 0); A and V unchanged.
  - 111 SBC: {C,A} = A + ~M + C; V per ADC rule using ~M; set N, Z.
  - Arithmetic is 9-bit internally; all results wrap mod 256.
- Flag ops:
  - 0x18 CLC and 0x38 SEC clear/set C.
  - 0xD8 CLD and 0xF8 SED clear/set D.
- Any other opcode is accepted as a NOP: no state change, DONE still pulses.
- P bit5 always reads 1; B is unchanged by this block.
- An op arriving in the same cycle as DONE is accepted (IDLE already active).

Optional Feature:
- DECIMAL_MODE_EN defined: when D = 1, ADC/SBC perform BCD.
  - Each nibble is adjusted by +/-6 when it exceeds 9 or borrows.
  - C = decimal carry/borrow.
  - N and Z come from the BCD result; V comes from the binary computation.
- Undefined: D is stored and readable but ignored; ADC/SBC are always binary.

Test Plan:
- R high 1 cycle -> REG_A = 00, P_FLAGS = 24, OP_READY = 1, WR_REQ = 0, DONE = 0.
- LDA# (A9, operand 80) at T0 -> at T0+2: REG_A = 80, N = 1, Z = 0, DONE pulse 1 cycle; OP_READY low during T0+1.
- CLC; LDA# 50; ADC# (69, 50) -> REG_A = A0, N = 1, V = 1, C = 0, Z = 0.
- A = 40, CMP# (C9, 41) -> C = 0, N = 1, Z = 0, REG_A = 40. Then CMP# 40 -> Z = 1, C = 1.
- A = 5A, STA abs (8D, EFF_ADDR 1234), WR_ACK delayed 3 cycles:
  - WR_REQ high 3+ cycles, WR_ADDR = 1234, WR_DATA = 5A.
  - DONE the cycle after ack; OP_READY low throughout.
  - Repeat with R asserted mid-WRITE -> WR_REQ = 0 next cycle, no DONE.
- SED; CLC; LDA# 19; ADC# 28 -> REG_A = 47 with DECIMAL_MODE_EN, REG_A = 41 without.
